// File: rtl/fetch_pkg.sv
// Shared types, constants and width helpers for the ROM fetch sequencer.
//
// Contents:
//   fetch_state_t   - fetch FSM states (S_FETCH assembles bytes, S_HOLD waits
//                     for FIFO space with the last byte on the ROM bus)
//   index_width()   - bits needed to index n items (minimum 1)
//   count_width()   - bits needed to hold a count of 0..n
//   BYTES_PER_INS   - ROM bytes per instruction in the default configuration
//   fetch_entry_t   - one prefetch buffer entry: instruction plus its PC
package fetch_pkg;

  localparam int DEF_ADDRESS_WIDTH = 8;
  localparam int DEF_DATA_WIDTH    = 8;
  localparam int DEF_INS_WIDTH     = 32;
  localparam int BYTES_PER_INS     = DEF_INS_WIDTH / DEF_DATA_WIDTH;

  typedef enum logic {
    S_FETCH,
    S_HOLD
  } fetch_state_t;

  function automatic int index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int count_width(input int n);
    return $clog2(n) + 1;
  endfunction

  // Sized by the package widths, so the top-level width parameters must be
  // left at (or overridden consistently with) these defaults.
  typedef struct packed {
    logic [DEF_INS_WIDTH-1:0]     instr;
    logic [DEF_ADDRESS_WIDTH-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous first-word-fall-through FIFO used as the prefetch buffer.
//
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   flush      - empties the FIFO; overrides push and pop in the same cycle
//   push       - write push_data (accepted when not full, or when popping)
//   push_data  - entry to write
//   pop        - drop the head entry (ignored when empty)
//   head_data  - current head entry, visible the cycle after it is pushed
//   empty/full - occupancy flags
//   count      - number of occupied entries
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int FIFO_DEPTH  = 2,
  parameter int ENTRY_WIDTH = 40
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic                               push,
  input  logic [ENTRY_WIDTH-1:0]             push_data,
  input  logic                               pop,
  output logic [ENTRY_WIDTH-1:0]             head_data,
  output logic                               empty,
  output logic                               full,
  output logic [count_width(FIFO_DEPTH)-1:0] count
);

  localparam int PTR_W = index_width(FIFO_DEPTH);
  localparam int CNT_W = count_width(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

  logic [ENTRY_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic                   do_push;
  logic                   do_pop;

  // When full, a push is still legal if the head leaves in the same cycle:
  // the write lands in the slot being vacated.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign head_data = mem[rd_ptr];

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // NOTE: storage has no reset; the count gates every read, so stale contents
  // are never observed and the array can map onto plain RAM cells.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/rom_fetch_sequencer.sv
// Fetch sequencer for a byte-wide asynchronous-read instruction ROM.
// Issues one byte address per cycle, assembles BYTES_PER_INS bytes (first
// byte most significant) into an instruction, buffers instructions in a
// prefetch FIFO and hands them to the core over valid/ready. A redirect
// flushes everything and restarts fetching at the aligned target.
//
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   rom_addr     - ROM byte address (fetch_pc + byte_cnt, wrapping)
//   rom_data     - ROM byte for rom_addr, same cycle
//   redirect_en  - one-cycle pulse loading redirect_pc (highest priority)
//   redirect_pc  - new fetch PC; low offset bits are forced to zero
//   instr_valid  - head instruction available
//   instr_ready  - core accepts the head instruction
//   instr        - head instruction, 0 when not valid
//   instr_pc     - PC of head instruction, 0 when not valid
//   fifo_count   - occupied prefetch entries
module rom_fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int INS_WIDTH     = DEF_INS_WIDTH,
  parameter int FIFO_DEPTH    = 2,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                               clk,
  input  logic                               rst,
  output logic [ADDRESS_WIDTH-1:0]           rom_addr,
  input  logic [DATA_WIDTH-1:0]              rom_data,
  input  logic                               redirect_en,
  input  logic [ADDRESS_WIDTH-1:0]           redirect_pc,
  output logic                               instr_valid,
  input  logic                               instr_ready,
  output logic [INS_WIDTH-1:0]               instr,
  output logic [ADDRESS_WIDTH-1:0]           instr_pc,
  output logic [count_width(FIFO_DEPTH)-1:0] fifo_count
);

  localparam int BPI   = INS_WIDTH / DATA_WIDTH;
  localparam int OFF_W = index_width(BPI);
  localparam logic [OFF_W-1:0]         LAST_BYTE  = OFF_W'(BPI - 1);
  localparam logic [ADDRESS_WIDTH-1:0] PC_STEP    = ADDRESS_WIDTH'(BPI);
  localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ~ADDRESS_WIDTH'(BPI - 1);

  fetch_state_t             state;
  logic [ADDRESS_WIDTH-1:0] fetch_pc;
  logic [OFF_W-1:0]         byte_cnt;
  logic [INS_WIDTH-1:0]     asm_reg;

  logic         at_last;
  logic         push;
  logic         pop;
  logic         fifo_empty;
  logic         fifo_full;
  fetch_entry_t push_entry;
  fetch_entry_t head_entry;

  // S_HOLD keeps byte_cnt at the last byte, so the same address and push
  // condition serve both states; the ROM is simply re-read while holding.
  assign rom_addr = fetch_pc + ADDRESS_WIDTH'(byte_cnt);
  assign at_last  = (byte_cnt == LAST_BYTE);
  assign pop      = !fifo_empty && instr_ready;
  assign push     = !redirect_en && at_last && (!fifo_full || pop);

  assign push_entry = '{instr: {asm_reg[INS_WIDTH-DATA_WIDTH-1:0], rom_data},
                        pc:    fetch_pc};

  fetch_fifo #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .ENTRY_WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_en),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign instr_valid = !fifo_empty;
  assign instr       = fifo_empty ? '0 : head_entry.instr;
  assign instr_pc    = fifo_empty ? '0 : head_entry.pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_FETCH;
      fetch_pc <= RESET_PC;
      byte_cnt <= '0;
      asm_reg  <= '0;
    end else if (redirect_en) begin
      state    <= S_FETCH;
      fetch_pc <= redirect_pc & ALIGN_MASK;
      byte_cnt <= '0;
      asm_reg  <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (!at_last) begin
            asm_reg  <= {asm_reg[INS_WIDTH-DATA_WIDTH-1:0], rom_data};
            byte_cnt <= byte_cnt + 1'b1;
          end else if (push) begin
            fetch_pc <= fetch_pc + PC_STEP;
            byte_cnt <= '0;
          end else begin
            state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (push) begin
            fetch_pc <= fetch_pc + PC_STEP;
            byte_cnt <= '0;
            state    <= S_FETCH;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_fetch_sequencer.sv
module tb_rom_fetch_sequencer;

  localparam int BPI   = 4;
  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       redirect_en = 1'b0;
  logic [7:0] redirect_pc = '0;
  logic       instr_ready = 1'b1;

  logic [7:0]  rom [256];

  logic [7:0]  rom_addr;
  logic [7:0]  rom_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [7:0]  instr_pc;
  logic [1:0]  fifo_count;

  logic [7:0]  rom_addr_w;
  logic [7:0]  rom_data_w;
  logic        instr_valid_w;
  logic [31:0] instr_w;
  logic [7:0]  instr_pc_w;
  logic [1:0]  fifo_count_w;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign rom_data   = rom[rom_addr];
  assign rom_data_w = rom[rom_addr_w];

  rom_fetch_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .fifo_count  (fifo_count)
  );

  rom_fetch_sequencer #(.RESET_PC(8'hFC)) dut_w (
    .clk         (clk),
    .rst         (rst),
    .rom_addr    (rom_addr_w),
    .rom_data    (rom_data_w),
    .redirect_en (1'b0),
    .redirect_pc (8'h00),
    .instr_valid (instr_valid_w),
    .instr_ready (1'b1),
    .instr       (instr_w),
    .instr_pc    (instr_pc_w),
    .fifo_count  (fifo_count_w)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Instructions are read straight from the ROM image at their PC; the model
  // tracks only the next PC, how many of its bytes have been read, and a
  // queue of completed instructions.
  typedef struct {
    logic [31:0] instr;
    logic [7:0]  pc;
  } m_entry_t;

  m_entry_t   m_q[$];
  logic [7:0] m_pc = 8'h00;
  int         m_k  = 0;

  function automatic logic [31:0] ins_at(input logic [7:0] pc);
    logic [31:0] v = '0;
    for (int i = 0; i < BPI; i++) begin
      logic [7:0] a = pc + 8'(i);
      v = {v[23:0], rom[a]};
    end
    return v;
  endfunction

  task automatic model_step();
    bit pop;
    if (rst) begin
      m_pc = 8'h00;
      m_k  = 0;
      m_q.delete();
    end else if (redirect_en) begin
      m_q.delete();
      m_pc = redirect_pc & 8'hFC;
      m_k  = 0;
    end else begin
      pop = (m_q.size() > 0) && instr_ready;
      if (m_k < BPI - 1) begin
        m_k++;
      end else if (m_q.size() < DEPTH || pop) begin
        if (pop) begin
          void'(m_q.pop_front());
          pop = 1'b0;
        end
        m_q.push_back('{instr: ins_at(m_pc), pc: m_pc});
        m_pc = m_pc + 8'(BPI);
        m_k  = 0;
      end
      if (pop) void'(m_q.pop_front());
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Single compare process: every cycle outside reset, mid-cycle.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      check("m_rom_addr", 32'(rom_addr), 32'(m_pc + 8'(m_k)));
      check("m_valid", 32'(instr_valid), 32'(m_q.size() > 0));
      check("m_instr", instr, (m_q.size() > 0) ? m_q[0].instr : 32'h0);
      check("m_pc", 32'(instr_pc), (m_q.size() > 0) ? 32'(m_q[0].pc) : 32'h0);
      check("m_count", 32'(fifo_count), 32'(m_q.size()));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'(i * 7 + 3);
    for (int i = 0; i < 8; i++)   rom[i] = 8'(i * 8'h11);
    rom[8'hFC] = 8'hDE;
    rom[8'hFD] = 8'hAD;
    rom[8'hFE] = 8'hBE;
    rom[8'hFF] = 8'hEF;

    // Phase A: free-running fetch with ready high
    instr_ready = 1'b1;
    do_reset();
    check("rst_addr", 32'(rom_addr), 32'h00);
    check("rst_valid", 32'(instr_valid), 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc", 32'(instr_pc), 32'h0);
    check("rst_count", 32'(fifo_count), 32'h0);
    check("rst_addr_w", 32'(rom_addr_w), 32'hFC);
    for (int i = 1; i < 4; i++) begin
      tick();
      check("step_addr", 32'(rom_addr), 32'(i));
    end
    tick();
    check("first_valid", 32'(instr_valid), 32'h1);
    check("first_instr", instr, 32'h0011_2233);
    check("first_pc", 32'(instr_pc), 32'h00);
    check("wrap_instr", instr_w, 32'hDEAD_BEEF);
    check("wrap_pc", 32'(instr_pc_w), 32'hFC);
    check("wrap_next_addr", 32'(rom_addr_w), 32'h00);
    tick(4);
    check("second_instr", instr, 32'h4455_6677);
    check("second_pc", 32'(instr_pc), 32'h04);

    // Phase B: core stalled from reset; FIFO fills and fetch holds
    instr_ready = 1'b0;
    do_reset();
    tick(20);
    check("stall_count", 32'(fifo_count), 32'h2);
    check("stall_addr", 32'(rom_addr), 32'h0B);
    check("stall_head", instr, 32'h0011_2233);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("pushpop_count", 32'(fifo_count), 32'h2);
    check("pushpop_head", instr, 32'h4455_6677);
    check("pushpop_addr", 32'(rom_addr), 32'h0C);
    tick(2);
    check("pre_rst_addr", 32'(rom_addr), 32'h0E);
    #2 rst = 1'b1;
    #1;
    check("async_valid", 32'(instr_valid), 32'h0);
    check("async_instr", instr, 32'h0);
    check("async_count", 32'(fifo_count), 32'h0);
    check("async_addr", 32'(rom_addr), 32'h00);

    // Phase C: clean restart, then redirect mid-assembly
    tick();
    rst = 1'b0;
    tick(4);
    check("restart_instr", instr, 32'h0011_2233);
    check("restart_count", 32'(fifo_count), 32'h1);
    tick(2);
    check("pre_redir_addr", 32'(rom_addr), 32'h06);
    redirect_en = 1'b1;
    redirect_pc = 8'h41;
    tick();
    redirect_en = 1'b0;
    check("redir_valid", 32'(instr_valid), 32'h0);
    check("redir_count", 32'(fifo_count), 32'h0);
    check("redir_addr", 32'(rom_addr), 32'h40);
    instr_ready = 1'b1;
    tick(4);
    check("redir_first_pc", 32'(instr_pc), 32'h40);
    check("redir_first_instr", instr, 32'hC3CA_D1D8);

    // Phase D: redirect against full FIFO, pop and last-byte push together
    instr_ready = 1'b0;
    tick(12);
    check("full_count", 32'(fifo_count), 32'h2);
    check("hold_addr", 32'(rom_addr), 32'h4B);
    redirect_en = 1'b1;
    redirect_pc = 8'h80;
    instr_ready = 1'b1;
    tick();
    redirect_en = 1'b0;
    check("flush_valid", 32'(instr_valid), 32'h0);
    check("flush_count", 32'(fifo_count), 32'h0);
    check("flush_addr", 32'(rom_addr), 32'h80);
    tick(6);

    // Wrap-around via redirect to an unaligned address near the top
    redirect_en = 1'b1;
    redirect_pc = 8'hFE;
    tick();
    redirect_en = 1'b0;
    check("wrapr_addr", 32'(rom_addr), 32'hFC);
    tick(4);
    check("wrapr_instr", instr, 32'hDEAD_BEEF);
    check("wrapr_pc", 32'(instr_pc), 32'hFC);
    check("wrapr_next", 32'(rom_addr), 32'h00);
    tick(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
